// File: rtl/systolic_array_tile_sequencer.sv
// systolic_array_tile_sequencer
// Self-sequencing controller for the output-stationary systolic array. One start
// pulse runs a configurable number of tiles: clear accumulators, stream K operand
// vectors from the top/left SRAMs, flush the skewed wavefront, then drain NUM_ROW
// result rows into the down SRAM. All outputs are registered; the registered
// values are decoded from the state being entered so they line up with it.
module systolic_array_tile_sequencer #(
    parameter int NUM_ROW              = 8,
    parameter int NUM_COL              = 8,
    parameter int LOG2_SRAM_BANK_DEPTH = 10,
    parameter int SKEW_VALID_EN        = 1,
    parameter int TILE_CNT_WIDTH       = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_start,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_k_len,
    input  logic [TILE_CNT_WIDTH-1:0]       i_num_tiles,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_top_rd_base_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_left_rd_base_addr,
    input  logic [LOG2_SRAM_BANK_DEPTH-1:0] i_down_wr_base_addr,
    input  logic [NUM_COL-1:0]              i_valid_down,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_err_cfg,
    output logic                            o_sa_clear,
    output logic                            o_top_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_top_rd_addr,
    output logic                            o_left_rd_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_left_rd_addr,
    output logic [NUM_COL-1:0]              o_valid_top,
    output logic [NUM_ROW-1:0]              o_valid_left,
    output logic                            o_drain_en,
    output logic [NUM_COL-1:0]              o_down_wr_en,
    output logic [LOG2_SRAM_BANK_DEPTH-1:0] o_down_wr_addr
);

    localparam int L         = LOG2_SRAM_BANK_DEPTH;
    localparam int TW        = TILE_CNT_WIDTH;
    localparam int FLUSH_LEN = NUM_ROW + NUM_COL - 1;
    localparam int FW        = $clog2(FLUSH_LEN + 1);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_CLEAR  = 3'd1;
    localparam logic [2:0] S_STREAM = 3'd2;
    localparam logic [2:0] S_FLUSH  = 3'd3;
    localparam logic [2:0] S_DRAIN  = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    // FSM state and latched run configuration
    logic [2:0]    r_state;
    logic [L-1:0]  r_k_len;
    logic [TW-1:0] r_num_tiles;
    logic [L-1:0]  r_top_base;
    logic [L-1:0]  r_left_base;
    logic [L-1:0]  r_down_base;

    // Progress counters
    logic [L-1:0]  r_k;          // vector index within the current tile
    logic [FW-1:0] r_flush;      // flush cycle index
    logic [L-1:0]  r_row;        // rows drained in the current tile
    logic [TW-1:0] r_tile;       // current tile index
    logic [L-1:0]  r_rd_off;     // t*K + k of the next read, runs across tiles
    logic [L-1:0]  r_row_base;   // t*NUM_ROW for the current tile

    // Registered outputs
    logic          r_busy;
    logic          r_done;
    logic          r_err_cfg;
    logic          r_sa_clear;
    logic          r_rd_en;
    logic [L-1:0]  r_top_rd_addr;
    logic [L-1:0]  r_left_rd_addr;
    logic          r_drain_en;
    logic [NUM_COL-1:0] r_down_wr_en;
    logic [L-1:0]  r_down_wr_addr;

    logic [2:0]    w_next;
    logic          w_cfg_bad;
    logic          w_stream_last;
    logic          w_flush_last;
    logic          w_row_write;
    logic          w_last_row;
    logic          w_last_tile;

    assign w_cfg_bad     = (i_k_len == '0) || (i_num_tiles == '0);
    assign w_stream_last = (r_k == (r_k_len - L'(1)));
    assign w_flush_last  = (r_flush == FW'(FLUSH_LEN - 1));
    assign w_row_write   = (r_state == S_DRAIN) && (|i_valid_down);
    assign w_last_row    = w_row_write && (r_row == L'(NUM_ROW - 1));
    assign w_last_tile   = (r_tile == (r_num_tiles - TW'(1)));

    // Next-state decode
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (i_start) w_next = w_cfg_bad ? S_DONE : S_CLEAR;
            S_CLEAR:  w_next = S_STREAM;
            S_STREAM: if (w_stream_last) w_next = S_FLUSH;
            S_FLUSH:  if (w_flush_last) w_next = S_DRAIN;
            S_DRAIN:  if (w_last_row) w_next = w_last_tile ? S_DONE : S_CLEAR;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    // State, configuration latch and progress counters
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_k_len     <= '0;
            r_num_tiles <= '0;
            r_top_base  <= '0;
            r_left_base <= '0;
            r_down_base <= '0;
            r_k         <= '0;
            r_flush     <= '0;
            r_row       <= '0;
            r_tile      <= '0;
            r_rd_off    <= '0;
            r_row_base  <= '0;
        end else begin
            r_state <= w_next;
            if ((r_state == S_IDLE) && i_start) begin
                r_k_len     <= i_k_len;
                r_num_tiles <= i_num_tiles;
                r_top_base  <= i_top_rd_base_addr;
                r_left_base <= i_left_rd_base_addr;
                r_down_base <= i_down_wr_base_addr;
                r_k         <= '0;
                r_flush     <= '0;
                r_row       <= '0;
                r_tile      <= '0;
                r_rd_off    <= '0;
                r_row_base  <= '0;
            end
            if (r_state == S_STREAM) begin
                r_k <= w_stream_last ? '0 : r_k + L'(1);
            end
            if (r_state == S_FLUSH) begin
                r_flush <= w_flush_last ? '0 : r_flush + FW'(1);
            end
            if (w_next == S_STREAM) begin
                r_rd_off <= r_rd_off + L'(1);
            end
            if (w_row_write) begin
                if (w_last_row) begin
                    r_row      <= '0;
                    r_row_base <= r_row_base + L'(NUM_ROW);
                    r_tile     <= r_tile + TW'(1);
                end else begin
                    r_row <= r_row + L'(1);
                end
            end
        end
    end

    // Output registers, decoded from the state being entered
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_busy         <= 1'b0;
            r_done         <= 1'b0;
            r_err_cfg      <= 1'b0;
            r_sa_clear     <= 1'b0;
            r_rd_en        <= 1'b0;
            r_top_rd_addr  <= '0;
            r_left_rd_addr <= '0;
            r_drain_en     <= 1'b0;
            r_down_wr_en   <= '0;
            r_down_wr_addr <= '0;
        end else begin
            r_busy     <= (w_next != S_IDLE);
            r_done     <= (w_next == S_DONE);
            // The only IDLE->DONE path is a rejected configuration.
            r_err_cfg  <= (w_next == S_DONE) && (r_state == S_IDLE);
            r_sa_clear <= (w_next == S_CLEAR);
            r_rd_en    <= (w_next == S_STREAM);
            r_top_rd_addr  <= (w_next == S_STREAM) ? (r_top_base + r_rd_off) : '0;
            r_left_rd_addr <= (w_next == S_STREAM) ? (r_left_base + r_rd_off) : '0;
            r_drain_en     <= (w_next == S_DRAIN);
            r_down_wr_en   <= w_row_write ? i_valid_down : '0;
            // Bottom row emerges first; address holds through drain stalls.
            if (w_row_write) begin
                r_down_wr_addr <= r_down_base + r_row_base + (L'(NUM_ROW - 1) - r_row);
            end
        end
    end

    generate
        if (SKEW_VALID_EN != 0) begin : g_skew
            logic [NUM_COL-1:0] r_vt_sh;
            logic [NUM_ROW-1:0] r_vl_sh;

            // Edge valids: bit n is the read enable delayed 1+n cycles
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vt_sh <= '0;
                    r_vl_sh <= '0;
                end else begin
                    r_vt_sh[0] <= r_rd_en;
                    r_vl_sh[0] <= r_rd_en;
                    for (int c = 1; c < NUM_COL; c++) r_vt_sh[c] <= r_vt_sh[c-1];
                    for (int r = 1; r < NUM_ROW; r++) r_vl_sh[r] <= r_vl_sh[r-1];
                end
            end

            assign o_valid_top  = r_vt_sh;
            assign o_valid_left = r_vl_sh;
        end else begin : g_flat
            logic r_v;

            // Edge valids: every bit is the read enable delayed one cycle
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) r_v <= 1'b0;
                else        r_v <= r_rd_en;
            end

            assign o_valid_top  = {NUM_COL{r_v}};
            assign o_valid_left = {NUM_ROW{r_v}};
        end
    endgenerate

    assign o_busy         = r_busy;
    assign o_done         = r_done;
    assign o_err_cfg      = r_err_cfg;
    assign o_sa_clear     = r_sa_clear;
    assign o_top_rd_en    = r_rd_en;
    assign o_top_rd_addr  = r_top_rd_addr;
    assign o_left_rd_en   = r_rd_en;
    assign o_left_rd_addr = r_left_rd_addr;
    assign o_drain_en     = r_drain_en;
    assign o_down_wr_en   = r_down_wr_en;
    assign o_down_wr_addr = r_down_wr_addr;

endmodule
